// File: rtl/bridge_pwm_pkg.sv
// rtl/bridge_pwm_pkg.sv - register map, field indices, state encoding and reset values for bridge_pwm_nphase
package bridge_pwm_pkg;

    localparam logic [3:0] ADDR_CTRL      = 4'd0;
    localparam logic [3:0] ADDR_STATUS    = 4'd1;
    localparam logic [3:0] ADDR_PERIOD    = 4'd2;
    localparam logic [3:0] ADDR_STEP      = 4'd3;
    localparam logic [3:0] ADDR_ONTIME    = 4'd4;
    localparam logic [3:0] ADDR_SAMP_OFS  = 4'd5;
    localparam logic [3:0] ADDR_OVERI_SET = 4'd6;
    localparam logic [3:0] ADDR_BURST     = 4'd7;
    localparam logic [3:0] ADDR_CYCLES    = 4'd8;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_POL   = 1;
    localparam int CTRL_BURST = 2;
    localparam int CTRL_FCLR  = 3;

    localparam int STAT_OC    = 2;
    localparam int STAT_FAULT = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [31:0] RST_PERIOD    = 32'h0000_0F9F;
    localparam logic [31:0] RST_STEP      = 32'h0000_0535;
    localparam logic [31:0] RST_ONTIME    = 32'h0000_0258;
    localparam logic [31:0] RST_SAMP_OFS  = 32'h0000_012C;
    localparam logic [31:0] RST_OVERI_SET = 32'h0000_012C;
    localparam logic [31:0] RST_BURST     = 32'h0000_0000;

endpackage

// File: rtl/pwm_phase_chan.sv
// rtl/pwm_phase_chan.sv - one PWM leg: on-counter started/restarted by a start pulse
module pwm_phase_chan #(
    parameter int CNT_W = 16
) (
    input  logic             SYSCLK,
    input  logic             RSTb,
    input  logic             clr,
    input  logic             start,
    input  logic [CNT_W-1:0] ontime,
    output logic             active,
    output logic [CNT_W-1:0] oncnt
);

    // oncnt runs 0..ontime-1 across the active cycles; widened so ontime at max never wraps
    logic last;
    assign last = ({1'b0, oncnt} + (CNT_W+1)'(1)) == {1'b0, ontime};

    always_ff @(posedge SYSCLK or negedge RSTb) begin
        if (!RSTb) begin
            active <= 1'b0;
            oncnt  <= '0;
        end else if (clr) begin
            active <= 1'b0;
            oncnt  <= '0;
        end else if (start) begin
            active <= (ontime != '0);
            oncnt  <= '0;
        end else if (active) begin
            if (last) begin
                active <= 1'b0;
                oncnt  <= '0;
            end else begin
                oncnt <= oncnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/bridge_pwm_nphase.sv
// rtl/bridge_pwm_nphase.sv - N-leg staggered bridge PWM with shadowed timing, burst mode and fault handling
module bridge_pwm_nphase
    import bridge_pwm_pkg::*;
#(
    parameter int N_PHASE     = 3,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               SYSCLK,
    input  logic               RSTb,
    input  logic [3:0]         OPB_ADDR,
    input  logic [31:0]        OPB_DI,
    input  logic               OPB_WE,
    input  logic               OPB_RE,
    output logic [31:0]        OPB_DO,
    output logic [N_PHASE-1:0] PD_PWM,
    output logic               PD_ENABLE,
    output logic               CUR_SAMP,
    input  logic               OVER_CURR,
    input  logic               FAULTb
);

    state_t state_q, state_d;

    logic             ctrl_en, ctrl_pol, ctrl_burst;
    logic [CNT_W-1:0] period_r, step_r, ontime_r, samp_r, overi_r, burst_r;
    logic [CNT_W-1:0] period_sh, step_sh, ontime_sh, samp_sh;
    logic [CNT_W-1:0] pcnt, cycles, oc_cnt;
    logic             oc_latched, fault_latched;

    logic [SYNC_STAGES-1:0] oc_sync, fb_sync;
    logic                   oc_s, fb_s;

    logic             wr_ctrl, en_eff, fclr;
    logic             oc_lat_d, ft_lat_d, fault_d;
    logic             run, wrap, burst_hit, run_entry;
    logic [CNT_W-1:0] wdata;
    logic [31:0]      rd_data;

    logic [N_PHASE-1:0] leg_act;
    logic [CNT_W-1:0]   leg0_cnt;

    assign wdata   = OPB_DI[CNT_W-1:0];
    assign wr_ctrl = OPB_WE && (OPB_ADDR == ADDR_CTRL);
    // A CTRL write takes effect on the state machine in the same cycle it is issued
    assign en_eff  = wr_ctrl ? OPB_DI[CTRL_EN] : ctrl_en;

    generate
        if (CNT_W < 32) begin : g_di_pad
            logic unused_di;
            assign unused_di = ^OPB_DI[31:CNT_W];
        end
    endgenerate

    always_ff @(posedge SYSCLK or negedge RSTb) begin
        if (!RSTb) begin
            oc_sync <= '0;
            fb_sync <= '1;
        end else begin
            oc_sync[0] <= OVER_CURR;
            fb_sync[0] <= FAULTb;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                oc_sync[i] <= oc_sync[i-1];
                fb_sync[i] <= fb_sync[i-1];
            end
        end
    end

    assign oc_s = oc_sync[SYNC_STAGES-1];
    assign fb_s = fb_sync[SYNC_STAGES-1];

    // Clearing wins over a set in the same cycle; the over-current count is already zero next cycle
    assign fclr     = wr_ctrl && OPB_DI[CTRL_FCLR] && (state_q == ST_FAULT) && !oc_s && fb_s;
    assign oc_lat_d = !fclr && (oc_latched || (oc_cnt > overi_r));
    assign ft_lat_d = !fclr && (fault_latched || !fb_s);
    assign fault_d  = oc_lat_d || ft_lat_d;

    assign run       = (state_q == ST_RUN);
    assign wrap      = run && (pcnt == period_sh);
    assign burst_hit = ctrl_burst && (burst_r != '0) && ((cycles + CNT_W'(1)) == burst_r);
    assign run_entry = !run && (state_d == ST_RUN);

    always_comb begin
        state_d = state_q;
        if (fault_d) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE:  if (en_eff) state_d = ST_RUN;
                ST_RUN: begin
                    if (!en_eff)               state_d = ST_IDLE;
                    else if (wrap && burst_hit) state_d = ST_DONE;
                end
                ST_DONE:  if (!en_eff) state_d = ST_IDLE;
                ST_FAULT: state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge SYSCLK or negedge RSTb) begin
        if (!RSTb) begin
            ctrl_en    <= 1'b0;
            ctrl_pol   <= 1'b1;
            ctrl_burst <= 1'b0;
            period_r   <= CNT_W'(RST_PERIOD);
            step_r     <= CNT_W'(RST_STEP);
            ontime_r   <= CNT_W'(RST_ONTIME);
            samp_r     <= CNT_W'(RST_SAMP_OFS);
            overi_r    <= CNT_W'(RST_OVERI_SET);
            burst_r    <= CNT_W'(RST_BURST);
        end else begin
            if (OPB_WE) begin
                case (OPB_ADDR)
                    ADDR_CTRL: begin
                        ctrl_en    <= OPB_DI[CTRL_EN];
                        ctrl_pol   <= OPB_DI[CTRL_POL];
                        ctrl_burst <= OPB_DI[CTRL_BURST];
                    end
                    ADDR_PERIOD:    period_r <= wdata;
                    ADDR_STEP:      step_r   <= wdata;
                    ADDR_ONTIME:    ontime_r <= wdata;
                    ADDR_SAMP_OFS:  samp_r   <= wdata;
                    ADDR_OVERI_SET: overi_r  <= wdata;
                    ADDR_BURST:     burst_r  <= wdata;
                    default: ;
                endcase
            end
            if (fault_d) ctrl_en <= 1'b0;
        end
    end

    always_ff @(posedge SYSCLK or negedge RSTb) begin
        if (!RSTb) begin
            state_q       <= ST_IDLE;
            oc_latched    <= 1'b0;
            fault_latched <= 1'b0;
            oc_cnt        <= '0;
            pcnt          <= '0;
            cycles        <= '0;
            period_sh     <= CNT_W'(RST_PERIOD);
            step_sh       <= CNT_W'(RST_STEP);
            ontime_sh     <= CNT_W'(RST_ONTIME);
            samp_sh       <= CNT_W'(RST_SAMP_OFS);
        end else begin
            state_q       <= state_d;
            oc_latched    <= oc_lat_d;
            fault_latched <= ft_lat_d;

            if (!oc_s)              oc_cnt <= '0;
            else if (oc_cnt != '1)  oc_cnt <= oc_cnt + CNT_W'(1);

            if (state_d != ST_RUN || run_entry || wrap) pcnt <= '0;
            else                                        pcnt <= pcnt + CNT_W'(1);

            if (run_entry)  cycles <= '0;
            else if (wrap)  cycles <= cycles + CNT_W'(1);

            if (run_entry || wrap) begin
                period_sh <= period_r;
                step_sh   <= step_r;
                ontime_sh <= ontime_r;
                samp_sh   <= samp_r;
            end
        end
    end

    generate
        for (genvar k = 0; k < N_PHASE; k++) begin : g_leg
            logic [CNT_W+2:0] start_at;
            logic [CNT_W-1:0] cnt_k;
            logic             start_k;

            assign start_at = {3'b000, step_sh} * (CNT_W+3)'(k);
            assign start_k  = run && ({3'b000, pcnt} == start_at);

            pwm_phase_chan #(.CNT_W(CNT_W)) u_chan (
                .SYSCLK (SYSCLK),
                .RSTb   (RSTb),
                .clr    (!run),
                .start  (start_k),
                .ontime (ontime_sh),
                .active (leg_act[k]),
                .oncnt  (cnt_k)
            );

            assign PD_PWM[k] = ctrl_pol ? (leg_act[k] && run) : !(leg_act[k] && run);

            if (k == 0) begin : g_cnt0
                assign leg0_cnt = cnt_k;
            end else begin : g_cnt_n
                logic unused_cnt;
                assign unused_cnt = ^cnt_k;
            end
        end
    endgenerate

    assign PD_ENABLE = run;
    assign CUR_SAMP  = run && leg_act[0] && (leg0_cnt == samp_sh);

    always_comb begin
        rd_data = '0;
        case (OPB_ADDR)
            ADDR_CTRL: begin
                rd_data[CTRL_EN]    = ctrl_en;
                rd_data[CTRL_POL]   = ctrl_pol;
                rd_data[CTRL_BURST] = ctrl_burst;
            end
            ADDR_STATUS: begin
                rd_data[1:0]        = state_q;
                rd_data[STAT_OC]    = oc_latched;
                rd_data[STAT_FAULT] = fault_latched;
            end
            ADDR_PERIOD:    rd_data = 32'(period_r);
            ADDR_STEP:      rd_data = 32'(step_r);
            ADDR_ONTIME:    rd_data = 32'(ontime_r);
            ADDR_SAMP_OFS:  rd_data = 32'(samp_r);
            ADDR_OVERI_SET: rd_data = 32'(overi_r);
            ADDR_BURST:     rd_data = 32'(burst_r);
            ADDR_CYCLES:    rd_data = 32'(cycles);
            default:        rd_data = '0;
        endcase
    end

    assign OPB_DO = OPB_RE ? rd_data : '0;

endmodule

// File: tb/tb_bridge_pwm_nphase.sv
// tb/tb_bridge_pwm_nphase.sv - scoreboard bench for bridge_pwm_nphase
module tb_bridge_pwm_nphase;

    localparam int NP = 3;

    logic          SYSCLK = 1'b0;
    logic          RSTb;
    logic [3:0]    OPB_ADDR;
    logic [31:0]   OPB_DI;
    logic          OPB_WE;
    logic          OPB_RE;
    logic [31:0]   OPB_DO;
    logic [NP-1:0] PD_PWM;
    logic          PD_ENABLE;
    logic          CUR_SAMP;
    logic          OVER_CURR;
    logic          FAULTb;

    always #5 SYSCLK = ~SYSCLK;

    bridge_pwm_nphase #(.N_PHASE(NP), .CNT_W(16), .SYNC_STAGES(2)) dut (
        .SYSCLK    (SYSCLK),
        .RSTb      (RSTb),
        .OPB_ADDR  (OPB_ADDR),
        .OPB_DI    (OPB_DI),
        .OPB_WE    (OPB_WE),
        .OPB_RE    (OPB_RE),
        .OPB_DO    (OPB_DO),
        .PD_PWM    (PD_PWM),
        .PD_ENABLE (PD_ENABLE),
        .CUR_SAMP  (CUR_SAMP),
        .OVER_CURR (OVER_CURR),
        .FAULTb    (FAULTb)
    );

    // bit 32 selects the observed output: 0 = OPB_DO, 1 = {CUR_SAMP, PD_ENABLE, PD_PWM}
    logic [32:0] exp_q[$];
    string       name_q[$];
    logic        obs_v = 1'b0;
    int          total = 0;
    int          bad   = 0;

    logic [32:0] m_e;
    logic [31:0] m_act;
    string       m_nm;

    always @(negedge SYSCLK) begin
        if (obs_v) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL underrun: DUT output observed with no expected entry");
            end else begin
                m_e   = exp_q.pop_front();
                m_nm  = name_q.pop_front();
                m_act = m_e[32] ? 32'({CUR_SAMP, PD_ENABLE, PD_PWM}) : OPB_DO;
                if (m_act !== m_e[31:0]) begin
                    bad++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h", m_nm, m_act, m_e[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        OPB_ADDR = a;
        OPB_DI   = d;
        OPB_WE   = 1'b1;
        tick();
        OPB_WE   = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] x, input string n);
        OPB_ADDR = a;
        OPB_RE   = 1'b1;
        exp_q.push_back({1'b0, x});
        name_q.push_back(n);
        obs_v = 1'b1;
        tick();
        OPB_RE = 1'b0;
        obs_v  = 1'b0;
    endtask

    task automatic pins(input logic [NP-1:0] pwm, input logic en, input logic samp, input string n);
        exp_q.push_back({1'b1, 32'({samp, en, pwm})});
        name_q.push_back(n);
        obs_v = 1'b1;
        tick();
        obs_v = 1'b0;
    endtask

    // hand model: leg k is active for p in [k*step+1, k*step+width]
    function automatic logic [NP-1:0] legs(input int p, input int step, input int width, input logic pol);
        logic [NP-1:0] r;
        logic          on;
        for (int k = 0; k < NP; k++) begin
            on   = (p >= k*step + 1) && (p <= k*step + width);
            r[k] = pol ? on : !on;
        end
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RSTb = 1'b0; OPB_ADDR = '0; OPB_DI = '0; OPB_WE = 1'b0; OPB_RE = 1'b0;
        OVER_CURR = 1'b0; FAULTb = 1'b1;
        repeat (3) tick();
        RSTb = 1'b1;
        tick();

        pins('0, 1'b0, 1'b0, "rst_pins");
        rd(4'd0, 32'h2,     "rst_ctrl");
        rd(4'd1, 32'h0,     "rst_status");
        rd(4'd2, 32'h0F9F,  "rst_period");
        rd(4'd3, 32'h0535,  "rst_step");
        rd(4'd4, 32'h0258,  "rst_ontime");
        rd(4'd5, 32'h012C,  "rst_samp");
        rd(4'd6, 32'h012C,  "rst_overi");
        rd(4'd7, 32'h0,     "rst_burst");
        rd(4'd8, 32'h0,     "rst_cycles");
        rd(4'd9, 32'h0,     "unmapped_9");
        wr(4'd12, 32'hFFFF);
        rd(4'd12, 32'h0,    "unmapped_12");

        // three staggered legs, two full periods
        wr(4'd2, 32'd29);
        wr(4'd3, 32'd10);
        wr(4'd4, 32'd5);
        wr(4'd0, 32'h3);
        for (int j = 0; j < 60; j++)
            pins(legs(j % 30, 10, 5, 1'b1), 1'b1, 1'b0, $sformatf("t1_pins_j%0d", j));
        rd(4'd8, 32'd2, "t1_cycles");
        rd(4'd1, 32'd1, "t1_status_run");

        // ONTIME written mid-period only takes effect from the next period
        wr(4'd4, 32'd8);
        for (int j = 63; j < 120; j++)
            pins(legs(j % 30, 10, (j >= 90) ? 8 : 5, 1'b1), 1'b1, 1'b0, $sformatf("t2_pins_j%0d", j));
        wr(4'd0, 32'h1);
        for (int j = 121; j < 150; j++)
            pins(legs(j % 30, 10, 8, 1'b0), 1'b1, 1'b0, $sformatf("t2_inv_j%0d", j));
        wr(4'd0, 32'h0);
        pins('1, 1'b0, 1'b0, "t2_idle_pol0_a");
        pins('1, 1'b0, 1'b0, "t2_idle_pol0_b");
        wr(4'd0, 32'h2);
        pins('0, 1'b0, 1'b0, "t2_idle_pol1");

        // burst of three 10-cycle periods
        wr(4'd2, 32'd9);
        wr(4'd3, 32'd3);
        wr(4'd4, 32'd2);
        wr(4'd7, 32'd3);
        wr(4'd0, 32'h7);
        for (int j = 0; j < 36; j++) begin
            if (j < 30) pins(legs(j % 10, 3, 2, 1'b1), 1'b1, 1'b0, $sformatf("t3_pins_j%0d", j));
            else        pins('0, 1'b0, 1'b0, $sformatf("t3_done_j%0d", j));
        end
        rd(4'd1, 32'd2, "t3_status_done");
        rd(4'd8, 32'd3, "t3_cycles");
        wr(4'd0, 32'h2);
        rd(4'd1, 32'd0, "t3_status_idle");

        // over-current: 4 high cycles at threshold 4 is tolerated, 6 is not
        wr(4'd6, 32'd4);
        OVER_CURR = 1'b1;
        repeat (4) tick();
        OVER_CURR = 1'b0;
        repeat (6) tick();
        rd(4'd1, 32'd0, "t4_no_oc");
        wr(4'd0, 32'h3);
        repeat (3) tick();
        rd(4'd1, 32'd1, "t4_run");
        OVER_CURR = 1'b1;
        repeat (6) tick();
        OVER_CURR = 1'b0;
        repeat (6) tick();
        rd(4'd1, 32'h7, "t4_status_fault");
        rd(4'd0, 32'h2, "t4_ctrl_en_cleared");
        pins('0, 1'b0, 1'b0, "t4_pins_fault");
        wr(4'd0, 32'hA);
        rd(4'd1, 32'd0, "t4_cleared");

        // driver fault: clear ignored while FAULTb still low
        FAULTb = 1'b0;
        tick();
        FAULTb = 1'b1;
        repeat (4) tick();
        rd(4'd1, 32'hB, "t5_status_fault");
        FAULTb = 1'b0;
        repeat (3) tick();
        wr(4'd0, 32'hA);
        rd(4'd1, 32'hB, "t5_clr_ignored");
        FAULTb = 1'b1;
        repeat (4) tick();
        wr(4'd0, 32'hA);
        rd(4'd1, 32'd0, "t5_cleared");
        rd(4'd0, 32'h2, "t5_ctrl");

        // sample strobe on leg0's third active cycle, then disabled by SAMP_OFS=ONTIME
        wr(4'd2, 32'd29);
        wr(4'd3, 32'd10);
        wr(4'd4, 32'd5);
        wr(4'd5, 32'd2);
        wr(4'd0, 32'h3);
        for (int j = 0; j < 30; j++)
            pins(legs(j % 30, 10, 5, 1'b1), 1'b1, (j % 30) == 3, $sformatf("t6_samp_j%0d", j));
        wr(4'd5, 32'd5);
        for (int j = 31; j < 63; j++)
            pins(legs(j % 30, 10, 5, 1'b1), 1'b1, j == 33, $sformatf("t6_nosamp_j%0d", j));
        RSTb = 1'b0;
        pins('0, 1'b0, 1'b0, "t6_rst_pins");
        rd(4'd0, 32'h2,    "t6_rst_ctrl");
        rd(4'd5, 32'h012C, "t6_rst_samp");
        RSTb = 1'b1;
        repeat (2) tick();

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: %0d expected entries never observed, required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bridge_pwm_nphase.md
Name: bridge_pwm_nphase

Overview:
Parametrised successor to the 3-leg bridge PWM controller. Generates N_PHASE equally staggered PWM legs from one period counter. Adds the following over the previous generation:
- programmable phase step
- shadowed period/on-time updates at period wrap
- burst mode
- an implemented current-sample strobe
- a RUN/FAULT state machine that drives PD_ENABLE

Sits between the OPB-style register bus and the power-driver pins. Everything runs on SYSCLK.

Parameters:
N_PHASE, 3, number of PWM legs (1..8)
CNT_W, 16, width of period/step/on-time/sample/over-current counters (8..32)
SYNC_STAGES, 2, synchroniser depth for OVER_CURR and FAULTb

Ports:
SYSCLK  in  1  sole clock; register bus is synchronous to it
RSTb  in  1  asynchronous active-low reset
OPB_ADDR  in  4  word register address
OPB_DI  in  32  write data
OPB_WE  in  1  write strobe, one-cycle
OPB_RE  in  1  read enable
OPB_DO  out  32  read data; combinational from OPB_ADDR when OPB_RE=1, else 0 (no tristate)
PD_PWM  out  N_PHASE  leg outputs; active level = polarity
PD_ENABLE  out  1  high only in RUN
CUR_SAMP  out  1  one-cycle current-sample strobe
OVER_CURR  in  1  async over-current comparator, active high
FAULTb  in  1  async driver fault, active low

Behaviour:
Interface: one clock, SYSCLK; reset RSTb is asynchronous, active-low.

Reset values:
- Outputs: PD_PWM = all 0 (polarity=1, inactive), PD_ENABLE=0, CUR_SAMP=0, state=IDLE.
- Registers: PERIOD=0x0F9F, STEP=0x0535, ONTIME=0x0258, SAMP_OFS=0x012C, OVERI_SET=0x012C, BURST=0, CTRL: enable=0, polarity=1, burst=0.

Register map (word addresses; fields LSB-aligned, wider registers truncated to CNT_W):
- 0 CTRL: [0] enable, [1] polarity, [2] burst_mode, [3] fault_clear (write-1 self-clearing pulse, reads 0).
- 1 STATUS (RO): [1:0] state, [2] oc_latched, [3] fault_latched.
- 2 PERIOD, 3 STEP, 4 ONTIME, 5 SAMP_OFS, 6 OVERI_SET, 7 BURST (RW).
- 8 CYCLES (RO): count of completed periods, CNT_W wide, wraps.
- Unmapped addresses read 0; writes to them are ignored.

State machine (IDLE=0, RUN=1, DONE=2, FAULT=3):
- IDLE->RUN: enable=1 and no latch set. The period counter starts at 0 on the first RUN cycle (write at cycle w, RUN and pcnt=0 at w+1). Shadow registers load at this point.
- RUN->IDLE: enable=0. Next cycle, all legs inactive and counters cleared.
- RUN->DONE: burst_mode=1 and CYCLES reaches BURST at a period wrap. BURST=0 means unlimited.
- DONE->IDLE: enable=0.
- any->FAULT: either latch sets. Hardware clears enable. FAULT has priority over a same-cycle register write.
- FAULT->IDLE: fault_clear written while the synchronised OVER_CURR=0 and FAULTb=1. This clears both latches. fault_clear is ignored outside FAULT or while a fault is still present.
- CYCLES clears on IDLE->RUN.

Period and phases:
- pcnt counts 0..PERIOD_sh and wraps to 0. PERIOD=0 degenerates to a 1-cycle period.
- PERIOD, STEP, ONTIME and SAMP_OFS are copied to shadows at wrap and at RUN entry; bus writes never disturb a period already in progress.
- Leg k starts when pcnt == k*STEP_sh. Compare width is CNT_W+3; a product > PERIOD_sh never starts.
- Start at cycle t: PD_PWM[k] is active on cycles t+1 .. t+ONTIME_sh, via a per-leg on-counter. ONTIME_sh=0 means never active.
- A start arriving while the leg is still active restarts the on-counter, so the pulse stays continuous.
- Outside RUN, every leg sits at !polarity.

Sample strobe: CUR_SAMP=1 for exactly one cycle when leg 0's on-counter equals SAMP_OFS_sh while leg 0 is active. SAMP_OFS_sh >= ONTIME_sh means no strobe.

Over-current:
- Synchronised OVER_CURR drives a saturating CNT_W counter of consecutive high cycles; the counter clears when the input is low.
- oc_latched sets when count > OVERI_SET.
- fault_latched sets on any synchronised FAULTb=0 cycle.
- Both latches are active in every state.

Decomposition:
- Package bridge_pwm_pkg: register address constants, CTRL/STATUS bit indices, state encoding, reset-value constants.
- One sub-module, pwm_phase_chan: per-leg on-counter with start/restart, active flag and on-count output. Instantiated N_PHASE times by generate.

Test Plan:
1. N_PHASE=3, PERIOD=29, STEP=10, ONTIME=5, enable -> relative to pcnt=0, leg0 high cycles 1-5, leg1 11-15, leg2 21-25; repeats every 30; PD_ENABLE=1.
2. Mid-period write ONTIME=8 -> current period keeps width 5; the next period shows width 8; polarity=0 inverts all legs, idle level 1.
3. burst_mode=1, BURST=3 -> exactly 3 periods, then state=DONE, legs inactive, CYCLES=3; clearing enable -> IDLE.
4. OVERI_SET=4, OVER_CURR high 4 cycles then low -> no fault; high 6 cycles -> FAULT, PD_ENABLE=0, legs inactive, STATUS[2]=1, CTRL[0] reads 0.
5. FAULTb low 1 cycle -> FAULT; fault_clear while FAULTb still low -> stays FAULT; after FAULTb returns high, fault_clear -> IDLE with latches cleared.
6. SAMP_OFS=2, ONTIME=5 -> CUR_SAMP one cycle per period, aligned to leg0's 3rd active cycle; SAMP_OFS=5 -> no strobe; RSTb asserted mid-pulse -> outputs take reset values immediately.
